// File: rtl/epu_out_writer.sv
// epu_out_writer: write sequencer for the EPU port of the output SRAM.
// Takes a valid/ready stream of 32-bit words and writes them to consecutive
// word addresses from a configured base. It also produces the start/end
// pulses that pass SRAM ownership between the EPU and the AXI slave.
module epu_out_writer #(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] A_epu,
    output logic [3:0]        WEB_epu,
    output logic [31:0]       DI_epu,
    output logic              start_signal,
    output logic              end_signal,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [LEN_W-1:0]  wr_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_WRITE = 3'd2,
        S_DRAIN = 3'd3,
        S_END   = 3'd4
    } state_e;

    localparam logic [3:0] WEB_WRITE = 4'h0;
    localparam logic [3:0] WEB_IDLE  = 4'hF;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q,  base_d;
    logic [LEN_W-1:0]    len_q,   len_d;
    logic [LEN_W-1:0]    cnt_q,   cnt_d;
    logic [ADDR_W-1:0]   a_q,     a_d;
    logic [3:0]          web_q,   web_d;
    logic [31:0]         di_q,    di_d;
    logic                err_q,   err_d;

    logic                beat;
    logic [LEN_W-1:0]    cnt_inc;
    logic [ADDR_W-1:0]   wr_addr;

    // A beat only exists in WRITE; in_ready is a pure function of state so it
    // never depends combinationally on in_valid.
    assign beat    = (state_q == S_WRITE) && in_valid;
    assign cnt_inc = cnt_q + LEN_W'(1);
    // Truncation to ADDR_W gives the modulo-2^ADDR_W address wrap.
    assign wr_addr = base_q + cnt_q[ADDR_W-1:0];

    // Next-state, write-port and error logic; everything defaults to hold/no-write.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        di_d    = di_q;
        web_d   = WEB_IDLE;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    if (cfg_len == '0) begin
                        err_d = 1'b1;
                    end else begin
                        base_d  = cfg_base;
                        len_d   = cfg_len;
                        cnt_d   = '0;
                        state_d = S_ARM;
                    end
                end
            end
            S_ARM: begin
                state_d = cfg_abort ? S_DRAIN : S_WRITE;
            end
            S_WRITE: begin
                if (beat) begin
                    a_d   = wr_addr;
                    di_d  = in_data;
                    web_d = WEB_WRITE;
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = S_DRAIN;
                    end
                end
                // An abort still lets a same-cycle beat land (handled above).
                if (cfg_abort) begin
                    state_d = S_DRAIN;
                end
            end
            // The final registered write is on the pins during DRAIN, so the
            // ownership hand-back in END never overlaps a write.
            S_DRAIN: begin
                state_d = S_END;
            end
            S_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Any start outside IDLE is rejected and leaves the active job alone.
        if (cfg_start && (state_q != S_IDLE)) begin
            err_d = 1'b1;
        end
    end

    // State and registered SRAM port; asynchronous reset abandons any job.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            web_q   <= WEB_IDLE;
            di_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            web_q   <= web_d;
            di_q    <= di_d;
            err_q   <= err_d;
        end
    end

    assign in_ready     = (state_q == S_WRITE);
    assign start_signal = (state_q == S_ARM);
    assign end_signal   = (state_q == S_END);
    assign done         = (state_q == S_END);
    assign busy         = (state_q != S_IDLE);
    assign err          = err_q;
    assign A_epu        = a_q;
    assign WEB_epu      = web_q;
    assign DI_epu       = di_q;
    assign wr_count     = cnt_q;

endmodule

// File: tb/tb_epu_out_writer.sv
// Bench for epu_out_writer: a timeline model of each job predicts every output
// per cycle, plus literal expectations for the directed scenarios.
module tb_epu_out_writer;

    localparam int ADDR_W = 12;
    localparam int LEN_W  = 13;

    logic              CLK = 1'b0;
    logic              RSTn;
    logic              cfg_start, cfg_abort;
    logic [ADDR_W-1:0] cfg_base;
    logic [LEN_W-1:0]  cfg_len;
    logic              in_valid;
    logic [31:0]       in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] A_epu;
    logic [3:0]        WEB_epu;
    logic [31:0]       DI_epu;
    logic              start_signal, end_signal, busy, done, err;
    logic [LEN_W-1:0]  wr_count;

    epu_out_writer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_base(cfg_base), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .A_epu(A_epu), .WEB_epu(WEB_epu), .DI_epu(DI_epu),
        .start_signal(start_signal), .end_signal(end_signal),
        .busy(busy), .done(done), .err(err), .wr_count(wr_count)
    );

    always #5 CLK = ~CLK;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    // A job is described by the edge its start was accepted (m_s) and the
    // edge its last beat/abort was taken (m_last). ARM is the cycle after m_s,
    // writing runs until m_last, END is one cycle after the DRAIN at m_last.
    int          cyc;
    bit          m_job;
    int          m_s, m_last, m_n, m_base, m_len;
    logic        e_busy, e_start, e_end, e_rdy, e_err;
    logic [3:0]  e_web;
    logic [11:0] e_a;
    logic [31:0] e_di;
    int          e_cnt;

    initial begin
        cyc = 0; m_job = 0; m_s = 0; m_last = -1; m_n = 0; m_base = 0; m_len = 0;
        e_busy = 0; e_start = 0; e_end = 0; e_rdy = 0; e_err = 0;
        e_web = 4'hF; e_a = '0; e_di = '0; e_cnt = 0;
        forever begin
            @(posedge CLK or negedge RSTn);
            if (!RSTn) begin
                m_job = 0; m_last = -1; m_n = 0;
                e_busy = 0; e_start = 0; e_end = 0; e_rdy = 0; e_err = 0;
                e_web = 4'hF; e_a = '0; e_di = '0; e_cnt = 0;
            end else begin
                bit wr;
                cyc++;
                wr = 0;
                if (e_rdy && in_valid) begin
                    e_a  = 12'((m_base + m_n) % 4096);
                    e_di = in_data;
                    wr   = 1;
                    m_n++;
                    if (m_n == m_len) m_last = cyc;
                end
                if (cfg_abort && m_job && m_last < 0 && cyc - 1 >= m_s) m_last = cyc;
                e_err = 0;
                if (cfg_start) begin
                    if (m_job || cfg_len == 0) e_err = 1;
                    else begin
                        m_job = 1; m_s = cyc; m_last = -1; m_n = 0;
                        m_base = int'(cfg_base); m_len = int'(cfg_len);
                    end
                end
                if (m_job && m_last >= 0 && cyc - 1 >= m_last + 1) m_job = 0;
                e_web   = wr ? 4'h0 : 4'hF;
                e_busy  = m_job;
                e_start = m_job && cyc == m_s;
                e_rdy   = m_job && cyc >= m_s + 1 && m_last < 0;
                e_end   = m_job && m_last >= 0 && cyc == m_last + 1;
                e_cnt   = m_n;
            end
        end
    end

    // ---------------- per-cycle compare and event log ----------------
    int tcyc = 0;
    int wa[$];
    int wd[$];
    int start_cnt, end_cnt, err_cnt, start_cyc, end_cyc;

    initial forever begin
        @(posedge CLK);
        tcyc++;
    end

    initial forever begin
        @(negedge CLK);
        if (RSTn) begin
            chk("busy",     32'(busy),         32'(e_busy));
            chk("start",    32'(start_signal), 32'(e_start));
            chk("end",      32'(end_signal),   32'(e_end));
            chk("done",     32'(done),         32'(e_end));
            chk("in_ready", 32'(in_ready),     32'(e_rdy));
            chk("err",      32'(err),          32'(e_err));
            chk("web",      32'(WEB_epu),      32'(e_web));
            chk("addr",     32'(A_epu),        32'(e_a));
            chk("data",     DI_epu,            e_di);
            chk("wr_count", 32'(wr_count),     32'(e_cnt));
            if (WEB_epu == 4'h0) begin
                wa.push_back(int'(A_epu));
                wd.push_back(int'(DI_epu));
            end
            if (start_signal) begin start_cnt++; start_cyc = tcyc; end
            if (end_signal)   begin end_cnt++;   end_cyc   = tcyc; end
            if (err)          err_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    int s_edge, last_edge, dbase;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_log();
        wa.delete(); wd.delete();
        start_cnt = 0; end_cnt = 0; err_cnt = 0; start_cyc = -1; end_cyc = -1;
    endtask

    task automatic start_job(input int base, input int len);
        cfg_start = 1'b1;
        cfg_base  = 12'(base);
        cfg_len   = 13'(len);
        tick();
        s_edge    = tcyc;
        cfg_start = 1'b0;
    endtask

    // Feed n beats; tog gives in_valid 1,0,1,0...; abort rides on beat abort_at;
    // rs_at raises an illegal cfg_start once while beat rs_at is pending.
    task automatic stream(input int n, input bit tog, input int abort_at, input int rs_at);
        int idx = 0;
        int step = 0;
        bit acc;
        bit rs_done = 0;
        while (idx < n && step < 20000) begin
            in_valid  = tog ? (step % 2 == 0) : 1'b1;
            in_data   = 32'(dbase + idx);
            acc       = in_ready && in_valid;
            cfg_abort = acc && (idx == abort_at);
            if (rs_at >= 0 && idx == rs_at && !rs_done) begin
                cfg_start = 1'b1; cfg_base = 12'h200; cfg_len = 13'd2; rs_done = 1;
            end
            tick();
            cfg_start = 1'b0;
            if (acc) begin idx++; last_edge = tcyc; end
            step++;
        end
        in_valid  = 1'b0;
        cfg_abort = 1'b0;
        chk("stream_beats", 32'(idx), 32'(n));
    endtask

    task automatic wait_end();
        int b = 0;
        while (end_cnt == 0 && b < 50) begin tick(); b++; end
        tick();
        chk("end_seen", 32'(end_cnt), 32'd1);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_A"},     32'(A_epu),        32'h0);
        chk({nm, "_WEB"},   32'(WEB_epu),      32'hF);
        chk({nm, "_DI"},    DI_epu,            32'h0);
        chk({nm, "_rdy"},   32'(in_ready),     32'h0);
        chk({nm, "_start"}, 32'(start_signal), 32'h0);
        chk({nm, "_end"},   32'(end_signal),   32'h0);
        chk({nm, "_busy"},  32'(busy),         32'h0);
        chk({nm, "_done"},  32'(done),         32'h0);
        chk({nm, "_err"},   32'(err),          32'h0);
        chk({nm, "_cnt"},   32'(wr_count),     32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int ea[4];
        RSTn = 1'b0; cfg_start = 0; cfg_abort = 0; cfg_base = '0; cfg_len = '0;
        in_valid = 0; in_data = '0; dbase = 0;
        clr_log();
        repeat (3) @(posedge CLK);
        #1;
        chk_reset("reset");
        RSTn = 1'b1;
        tick();

        // Basic job: base 0x010, len 4, data 0xA0..0xA3, in_valid held high.
        clr_log(); dbase = 'hA0;
        start_job('h010, 4);
        stream(4, 0, -1, -1);
        wait_end();
        ea = '{'h010, 'h011, 'h012, 'h013};
        chk("basic_nwr", 32'(wa.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("basic_addr", 32'(wa[i]), 32'(ea[i]));
            chk("basic_data", 32'(wd[i]), 32'('hA0 + i));
        end
        chk("basic_cnt", 32'(wr_count), 32'd4);
        // Edge that samples cfg_start is edge 0; ARM is seen right after it.
        chk("basic_start_lat", 32'(start_cyc - s_edge), 32'd0);
        // END follows the last-beat edge by one further edge (DRAIN in between).
        chk("basic_end_lat", 32'(end_cyc - last_edge), 32'd1);

        // Wrap with bubbles: base 0xFFE, len 4, in_valid toggling.
        clr_log(); dbase = 'h55;
        start_job('hFFE, 4);
        stream(4, 1, -1, -1);
        wait_end();
        ea = '{'hFFE, 'hFFF, 'h000, 'h001};
        chk("wrap_nwr", 32'(wa.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("wrap_addr", 32'(wa[i]), 32'(ea[i]));

        // Zero length start is rejected.
        clr_log();
        start_job('h040, 0);
        tick(); tick();
        chk("len0_err", 32'(err_cnt), 32'd1);
        chk("len0_start", 32'(start_cnt), 32'd0);
        chk("len0_busy", 32'(busy), 32'd0);

        // Start during WRITE: rejected, original job completes unchanged.
        clr_log(); dbase = 'h1000;
        start_job('h100, 6);
        stream(6, 0, -1, 2);
        wait_end();
        chk("busy_start_err", 32'(err_cnt), 32'd1);
        chk("busy_start_nstart", 32'(start_cnt), 32'd1);
        chk("busy_start_nwr", 32'(wa.size()), 32'd6);
        chk("busy_start_first", 32'(wa[0]), 32'h100);
        chk("busy_start_last", 32'(wa[5]), 32'h105);
        chk("busy_start_cnt", 32'(wr_count), 32'd6);

        // Abort with the 3rd accepted beat of a len-10 job.
        clr_log(); dbase = 'h2000;
        start_job('h020, 10);
        stream(3, 0, 2, -1);
        wait_end();
        chk("abort_nwr", 32'(wa.size()), 32'd3);
        chk("abort_cnt", 32'(wr_count), 32'd3);
        chk("abort_last_addr", 32'(wa[2]), 32'h022);
        chk("abort_end_lat", 32'(end_cyc - last_edge), 32'd1);

        // Reset mid-job after 5 beats, then a minimal len-1 job.
        clr_log(); dbase = 'h3000;
        start_job('h300, 8);
        stream(5, 0, -1, -1);
        #2;
        RSTn = 1'b0;
        #1;
        chk_reset("midrst");
        tick(); tick();
        RSTn = 1'b1;
        tick();
        chk("midrst_no_end", 32'(end_cnt), 32'd0);
        clr_log(); dbase = 'h4000;
        start_job('h005, 1);
        stream(1, 0, -1, -1);
        wait_end();
        chk("min_nwr", 32'(wa.size()), 32'd1);
        chk("min_addr", 32'(wa[0]), 32'h005);
        chk("min_data", 32'(wd[0]), 32'h4000);
        // cfg_start edge 0 -> END in cycle 4, i.e. three edges later.
        chk("min_start_to_end", 32'(end_cyc - s_edge), 32'd3);

        // Full length job: 4096 words from 0x800, wrapping to end at 0x7FF.
        clr_log(); dbase = 'h10000;
        start_job('h800, 4096);
        stream(4096, 0, -1, -1);
        wait_end();
        chk("full_nwr", 32'(wa.size()), 32'd4096);
        chk("full_first", 32'(wa[0]), 32'h800);
        chk("full_wrap", 32'(wa[2048]), 32'h000);
        chk("full_last", 32'(wa[4095]), 32'h7FF);
        chk("full_cnt", 32'(wr_count), 32'd4096);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
